// File: rtl/connect4_pkg.sv
// connect4_pkg: shared constants, FSM state type and the column one-hot
// decoder used by the drop controller.
package connect4_pkg;

  localparam int NUM_COLS    = 16;
  localparam int FALL_CYCLES = 15;

  // Fall counter starts one below the cycle count because the terminal
  // count (0) is itself a FALL cycle.
  localparam logic [3:0] FALL_LOAD = 4'(FALL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLACE = 2'd1,
    FALL  = 2'd2
  } state_e;

  // One-hot column select from a column index.
  function automatic logic [NUM_COLS-1:0] col_onehot(input logic [3:0] idx);
    col_onehot = {{(NUM_COLS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/drop_controller_if.sv
// drop_controller_if: button/board inputs and cursor/placement outputs of
// the drop controller.
//   master: drives buttons, game_over, col_full; observes outputs.
//   slave : the controller itself.
interface drop_controller_if;
  import connect4_pkg::*;

  logic                left;
  logic                right;
  logic                drop;
  logic                game_over;
  logic [NUM_COLS-1:0] col_full;
  logic                player;
  logic [NUM_COLS-1:0] placement;
  logic [NUM_COLS-1:0] dropping;
  logic [3:0]          cursor;
  logic                busy;

  modport master (
    output left, right, drop, game_over, col_full,
    input  player, placement, dropping, cursor, busy
  );

  modport slave (
    input  left, right, drop, game_over, col_full,
    output player, placement, dropping, cursor, busy
  );

endinterface

// File: rtl/btn_pulse.sv
// btn_pulse: turns a level button into a single-cycle registered pulse on
// its 0->1 transition.
//   clk   : system clock
//   RST   : synchronous active-high reset
//   btn   : level button input
//   pulse : one-cycle strobe, high the cycle after the rising edge is sampled
module btn_pulse (
  input  logic clk,
  input  logic RST,
  input  logic btn,
  output logic pulse
);

  logic btn_q, btn_d;
  logic arm_q, arm_d;
  logic pulse_q, pulse_d;

  // Edge detect; arm_q blocks the first post-reset cycle so a button held
  // through reset release is seen as already pressed, not as a new press.
  always_comb begin
    btn_d   = btn;
    arm_d   = 1'b1;
    pulse_d = btn & ~btn_q & arm_q;
  end

  // Edge-detector registers.
  always_ff @(posedge clk) begin
    if (RST) begin
      btn_q   <= 1'b0;
      arm_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      btn_q   <= btn_d;
      arm_q   <= arm_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/drop_controller.sv
// drop_controller: column cursor and piece-drop sequencer.
//   clk : system clock (rising edge)
//   RST : synchronous active-high reset
//   bus : slave side of drop_controller_if
//         in : left, right, drop (level buttons), game_over, col_full[15:0]
//         out: player, placement[15:0] (one-hot strobe), dropping[15:0]
//              (cursor indicator), cursor[3:0], busy
// All outputs are flops computed from next-state values, so nothing reaches
// an output combinationally from an input.
module drop_controller
  import connect4_pkg::*;
(
  input  logic             clk,
  input  logic             RST,
  drop_controller_if.slave bus
);

  logic left_p, right_p, drop_p;

  btn_pulse u_left  (.clk(clk), .RST(RST), .btn(bus.left),  .pulse(left_p));
  btn_pulse u_right (.clk(clk), .RST(RST), .btn(bus.right), .pulse(right_p));
  btn_pulse u_drop  (.clk(clk), .RST(RST), .btn(bus.drop),  .pulse(drop_p));

  state_e              state_q, state_d;
  logic [3:0]          cursor_q, cursor_d;
  logic                player_q, player_d;
  logic [3:0]          fall_cnt_q, fall_cnt_d;
  logic [NUM_COLS-1:0] placement_q, placement_d;
  logic [NUM_COLS-1:0] dropping_q, dropping_d;
  logic                busy_q, busy_d;

  // Next-state, cursor, fall counter and output decode.
  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    player_d   = player_q;
    fall_cnt_d = fall_cnt_q;
    case (state_q)
      IDLE: begin
        // Drop is judged on the pre-move cursor and wins over a move.
        if (drop_p && !bus.game_over && !bus.col_full[cursor_q]) begin
          state_d = PLACE;
        end else if (left_p && !right_p) begin
          cursor_d = cursor_q - 4'd1;
        end else if (right_p && !left_p) begin
          cursor_d = cursor_q + 4'd1;
        end else begin
          cursor_d = cursor_q;
        end
      end
      PLACE: begin
        state_d    = FALL;
        fall_cnt_d = FALL_LOAD;
      end
      FALL: begin
        if (fall_cnt_q == 4'd0) begin
          state_d  = IDLE;
          player_d = ~player_q;
        end else begin
          fall_cnt_d = fall_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    placement_d = (state_d == PLACE) ? col_onehot(cursor_d) : {NUM_COLS{1'b0}};
    dropping_d  = (state_d == IDLE && !bus.game_over) ? col_onehot(cursor_d)
                                                      : {NUM_COLS{1'b0}};
    busy_d      = (state_d != IDLE);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= IDLE;
      cursor_q    <= 4'd0;
      player_q    <= 1'b0;
      fall_cnt_q  <= 4'd0;
      placement_q <= {NUM_COLS{1'b0}};
      dropping_q  <= {{(NUM_COLS-1){1'b0}}, 1'b1};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      player_q    <= player_d;
      fall_cnt_q  <= fall_cnt_d;
      placement_q <= placement_d;
      dropping_q  <= dropping_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.player    = player_q;
  assign bus.placement = placement_q;
  assign bus.dropping  = dropping_q;
  assign bus.cursor    = cursor_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_drop_controller.sv
// Directed bench for drop_controller: inputs driven on the falling edge,
// outputs sampled on the falling edge, expectations hand-computed.
module tb_drop_controller;

  logic clk;
  logic RST;
  int   n_vec = 0;
  int   n_err = 0;

  drop_controller_if bus ();

  drop_controller dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stimulus: pulse one button (0=left,1=right,2=both,3=drop) for one cycle
  // and let the result settle.
  task automatic press(input int which);
    @(negedge clk);
    bus.left  = (which == 0 || which == 2);
    bus.right = (which == 1 || which == 2);
    bus.drop  = (which == 3);
    @(negedge clk);
    bus.left  = 1'b0;
    bus.right = 1'b0;
    bus.drop  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (bus.placement !== 16'h0000) begin n_err++; $display("FAIL rst_placement: got %h want 0000", bus.placement); end
    n_vec++; if (bus.dropping !== 16'h0001) begin n_err++; $display("FAIL rst_dropping: got %h want 0001", bus.dropping); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.cursor !== 4'd0) begin n_err++; $display("FAIL rst_cursor: got %0d want 0", bus.cursor); end
    n_vec++; if (bus.player !== 1'b0) begin n_err++; $display("FAIL rst_player: got %b want 0", bus.player); end
    RST = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (bus.dropping !== 16'h0001) begin n_err++; $display("FAIL post_rst_dropping: got %h want 0001", bus.dropping); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL post_rst_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_left_wrap();
    press(0);
    n_vec++; if (bus.cursor !== 4'd15) begin n_err++; $display("FAIL left_wrap_cursor: got %0d want 15", bus.cursor); end
    n_vec++; if (bus.dropping !== 16'h8000) begin n_err++; $display("FAIL left_wrap_dropping: got %h want 8000", bus.dropping); end
    press(1);
    n_vec++; if (bus.cursor !== 4'd0) begin n_err++; $display("FAIL right_wrap_cursor: got %0d want 0", bus.cursor); end
    n_vec++; if (bus.dropping !== 16'h0001) begin n_err++; $display("FAIL right_wrap_dropping: got %h want 0001", bus.dropping); end
  endtask

  task automatic test_right();
    repeat (3) press(1);
    n_vec++; if (bus.cursor !== 4'd3) begin n_err++; $display("FAIL right3_cursor: got %0d want 3", bus.cursor); end
    n_vec++; if (bus.dropping !== 16'h0008) begin n_err++; $display("FAIL right3_dropping: got %h want 0008", bus.dropping); end
    n_vec++; if (bus.player !== 1'b0) begin n_err++; $display("FAIL right3_player: got %b want 0", bus.player); end
  endtask

  task automatic test_simultaneous();
    press(2);
    n_vec++; if (bus.cursor !== 4'd3) begin n_err++; $display("FAIL both_cursor: got %0d want 3", bus.cursor); end
  endtask

  task automatic test_drop();
    int plc_cnt, busy_cnt;
    logic [15:0] plc_val;
    plc_cnt = 0; busy_cnt = 0; plc_val = 16'h0000;
    @(negedge clk); bus.drop = 1'b1;
    @(negedge clk); bus.drop = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.placement !== 16'h0000) begin plc_cnt++; plc_val = bus.placement; end
      if (bus.busy === 1'b1) busy_cnt++;
    end
    n_vec++; if (plc_cnt !== 1) begin n_err++; $display("FAIL drop_plc_count: got %0d want 1", plc_cnt); end
    n_vec++; if (plc_val !== 16'h0008) begin n_err++; $display("FAIL drop_plc_value: got %h want 0008", plc_val); end
    n_vec++; if (busy_cnt !== 16) begin n_err++; $display("FAIL drop_busy_cycles: got %0d want 16", busy_cnt); end
    n_vec++; if (bus.player !== 1'b1) begin n_err++; $display("FAIL drop_player: got %b want 1", bus.player); end
    n_vec++; if (bus.dropping !== 16'h0008) begin n_err++; $display("FAIL drop_dropping_after: got %h want 0008", bus.dropping); end
  endtask

  task automatic test_fall_moves();
    @(negedge clk); bus.drop = 1'b1;
    @(negedge clk); bus.drop = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++; if (bus.dropping !== 16'h0000) begin n_err++; $display("FAIL fall_dropping: got %h want 0000", bus.dropping); end
    press(1);
    n_vec++; if (bus.cursor !== 4'd3) begin n_err++; $display("FAIL fall_right_cursor: got %0d want 3", bus.cursor); end
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL fall_right_busy: got %b want 1", bus.busy); end
    press(0);
    n_vec++; if (bus.cursor !== 4'd3) begin n_err++; $display("FAIL fall_left_cursor: got %0d want 3", bus.cursor); end
    repeat (10) @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL fall_end_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.cursor !== 4'd3) begin n_err++; $display("FAIL fall_end_cursor: got %0d want 3", bus.cursor); end
    n_vec++; if (bus.player !== 1'b0) begin n_err++; $display("FAIL fall_end_player: got %b want 0", bus.player); end
  endtask

  task automatic test_col_full();
    int hits;
    hits = 0;
    bus.col_full = 16'h0008;
    @(negedge clk); bus.drop = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.placement !== 16'h0000 || bus.busy !== 1'b0) hits++;
    end
    bus.drop = 1'b0;
    n_vec++; if (hits !== 0) begin n_err++; $display("FAIL full_activity: got %0d busy/placement cycles want 0", hits); end
    n_vec++; if (bus.player !== 1'b0) begin n_err++; $display("FAIL full_player: got %b want 0", bus.player); end
    n_vec++; if (bus.cursor !== 4'd3) begin n_err++; $display("FAIL full_cursor: got %0d want 3", bus.cursor); end
    bus.col_full = 16'h0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_drop_held();
    int plc_cnt;
    plc_cnt = 0;
    @(negedge clk); bus.drop = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.placement !== 16'h0000) plc_cnt++;
    end
    bus.drop = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.placement !== 16'h0000) plc_cnt++;
    end
    n_vec++; if (plc_cnt !== 1) begin n_err++; $display("FAIL held_plc_count: got %0d want 1", plc_cnt); end
    n_vec++; if (bus.player !== 1'b1) begin n_err++; $display("FAIL held_player: got %b want 1", bus.player); end
  endtask

  task automatic test_reset_mid_fall();
    int busy_cnt;
    busy_cnt = 0;
    bus.drop = 1'b1;
    repeat (9) @(negedge clk);
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL midfall_busy_before: got %b want 1", bus.busy); end
    RST = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.player !== 1'b0) begin n_err++; $display("FAIL midfall_player: got %b want 0", bus.player); end
    n_vec++; if (bus.cursor !== 4'd0) begin n_err++; $display("FAIL midfall_cursor: got %0d want 0", bus.cursor); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midfall_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.placement !== 16'h0000) begin n_err++; $display("FAIL midfall_placement: got %h want 0000", bus.placement); end
    RST = 1'b0;
    // drop still held through reset release: must not start a drop
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) busy_cnt++;
    end
    bus.drop = 1'b0;
    n_vec++; if (busy_cnt !== 0) begin n_err++; $display("FAIL held_thru_reset: got %0d busy cycles want 0", busy_cnt); end
    n_vec++; if (bus.dropping !== 16'h0001) begin n_err++; $display("FAIL held_thru_reset_dropping: got %h want 0001", bus.dropping); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_game_over();
    int hits;
    hits = 0;
    bus.game_over = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (bus.dropping !== 16'h0000) begin n_err++; $display("FAIL go_dropping: got %h want 0000", bus.dropping); end
    bus.drop = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.placement !== 16'h0000 || bus.busy !== 1'b0) hits++;
    end
    bus.drop = 1'b0;
    n_vec++; if (hits !== 0) begin n_err++; $display("FAIL go_activity: got %0d busy/placement cycles want 0", hits); end
    n_vec++; if (bus.player !== 1'b0) begin n_err++; $display("FAIL go_player: got %b want 0", bus.player); end
    bus.game_over = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (bus.dropping !== 16'h0001) begin n_err++; $display("FAIL go_clear_dropping: got %h want 0001", bus.dropping); end
  endtask

  task automatic test_game_over_mid_fall();
    @(negedge clk); bus.drop = 1'b1;
    repeat (5) @(negedge clk);
    bus.game_over = 1'b1;
    bus.drop      = 1'b0;
    repeat (20) @(negedge clk);
    n_vec++; if (bus.player !== 1'b1) begin n_err++; $display("FAIL go_midfall_player: got %b want 1", bus.player); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL go_midfall_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.dropping !== 16'h0000) begin n_err++; $display("FAIL go_midfall_dropping: got %h want 0000", bus.dropping); end
    bus.game_over = 1'b0;
  endtask

  initial begin
    RST           = 1'b1;
    bus.left      = 1'b0;
    bus.right     = 1'b0;
    bus.drop      = 1'b0;
    bus.game_over = 1'b0;
    bus.col_full  = 16'h0000;
    test_reset();
    test_left_wrap();
    test_right();
    test_simultaneous();
    test_drop();
    test_fall_moves();
    test_col_full();
    test_drop_held();
    test_reset_mid_fall();
    test_game_over();
    test_game_over_mid_fall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/drop_controller.md
DROP_CONTROLLER -- requirements
Module: drop_controller

Interface
REQ-001 The block SHALL have the following ports:
- clk  input  1  system clock; all state changes on rising edge.
- RST  input  1  synchronous, active-high reset.
- left  input  1  level button; move the cursor one column toward 0.
- right  input  1  level button; move the cursor one column toward 15.
- drop  input  1  level button; request a piece drop in the cursor column.
- game_over  input  1  high = board frozen; no drops accepted.
- col_full  input  16  bit c = top playable row of column c is occupied (RedPixels[1] | GrnPixels[1] of that column).
- player  output  1  current player (0 = red, 1 = green); fans out to every column.
- placement  output  16  one-hot per-column placement strobe.
- dropping  output  16  one-hot per-column cursor indicator (row 0).
- cursor  output  4  current cursor column index.
- busy  output  1  high while a piece is in flight.

Function
REQ-002 Each of left, right and drop SHALL be converted to a single-cycle pulse on its 0->1 transition, registered one cycle after the input edge is sampled; holding a button SHALL produce exactly one pulse.
REQ-003 The FSM SHALL have three states: IDLE, PLACE and FALL.
REQ-004 In IDLE, a left pulse SHALL decrement cursor, and 0 SHALL wrap to 15.
REQ-005 In IDLE, a right pulse SHALL increment cursor, and 15 SHALL wrap to 0.
REQ-006 Simultaneous left and right pulses SHALL leave cursor unchanged.
REQ-007 In PLACE and FALL, left and right pulses SHALL be discarded and cursor SHALL hold.
REQ-008 In IDLE, a drop pulse with col_full[cursor]=0 and game_over=0 SHALL cause the transition IDLE->PLACE on that edge.
REQ-009 A drop pulse with col_full[cursor]=1 or game_over=1 SHALL be ignored: state, player and cursor are unchanged.
REQ-010 If drop and a move pulse occur in the same IDLE cycle, the drop SHALL be evaluated against the pre-move cursor, and the move SHALL be discarded when the drop is accepted.
REQ-011 In PLACE (exactly one cycle), placement SHALL equal one-hot(cursor), and the FSM SHALL then go to FALL.
REQ-012 In all other states placement SHALL be 16'h0000.
REQ-013 FALL SHALL last exactly 15 cycles, counted by a 4-bit counter loaded with 14 on PLACE->FALL and decremented to 0.
REQ-014 On FALL->IDLE, player SHALL toggle.
REQ-015 Total drop cost SHALL be 16 cycles from the PLACE entry edge to the IDLE re-entry edge.
REQ-016 dropping SHALL equal one-hot(cursor) in IDLE when game_over=0, and 16'h0000 otherwise.
REQ-017 busy SHALL be 1 exactly in PLACE and FALL.
REQ-018 game_over rising during PLACE or FALL SHALL NOT abort the drop: the sequence completes and player toggles.
REQ-019 All outputs SHALL be driven from registers or from decode of registered state only, with no combinational path from any input.

Reset
REQ-020 When RST=1 at a clock edge, the block SHALL set: state=IDLE, cursor=0, player=0, fall counter=0, and all button-edge registers=0.
REQ-021 During and immediately after reset: placement=0, dropping=16'h0001, busy=0.
REQ-022 RST asserted mid-PLACE or mid-FALL SHALL abandon the drop without toggling player; column contents are cleared by the same RST.
REQ-023 A button held through reset release SHALL NOT generate a pulse.

Structure
REQ-024 Package connect4_pkg SHALL hold NUM_COLS=16, FALL_CYCLES=15 and the state enum (IDLE, PLACE, FALL).
REQ-025 One sub-module, btn_pulse, SHALL implement the per-button rising-edge detector and SHALL be instantiated three times.
REQ-026 The top level SHALL contain the FSM, the cursor counter, the fall counter and the one-hot decoders.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- Reset, then 3 right presses -> cursor=3, dropping=16'h0008, player=0.
- 1 left press from cursor=0 -> cursor=15, dropping=16'h8000.
- Drop at cursor=3 with col_full=0 -> placement=16'h0008 for exactly 1 cycle, busy high for 16 cycles, then player=1.
- Right press and left presses during FALL -> cursor unchanged.
- col_full[3]=1 and drop at cursor=3 -> placement stays 0, busy stays 0, player unchanged.
- drop held high for 40 cycles -> exactly one placement pulse.
- RST asserted at FALL cycle 7 -> next cycle state=IDLE, player=0, cursor=0, busy=0.
- game_over=1 then drop -> no placement, dropping=0.
